mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Memory-side responder for the tagged processor/memory bus driven by the fetch and data caches.
//  - Accepts BUS_LOAD/BUS_STORE commands.
//  - Answers each accepted command in the same cycle with a non-zero response tag.
//  - Returns load data LATENCY cycles later on mem2proc_data/mem2proc_tag.
//  - Holds a 64-bit word-addressed backing store.
//  - Replaces the behavioural memory model in synthesizable system builds.
// PARAMETERS
//  LATENCY    10    cycles from load acceptance to earliest tag return (>=1)
//  NUM_TAGS   15    outstanding load slots, tags 1..NUM_TAGS (<=15; tag 0 = none)
//  MEM_WORDS  1024  64-bit words of storage (power of 2)
// PORTS
//  clock             in   1   system clock
//  reset             in   1   asynchronous, active-high reset
//  proc2mem_command  in   2   BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2 (3 treated as NONE)
//  proc2mem_addr     in   64  byte address; word index = addr[3 +: log2(MEM_WORDS)]
//  proc2mem_data     in   64  store data
//  mem2proc_response out  4   combinational; accepted tag, 0 = refused/no command
//  mem2proc_data     out  64  registered; returned load data
//  mem2proc_tag      out  4   registered; tag completing this cycle, 0 = none
//  mem_busy          in   1   only with MEM_REFUSE_EN; forces refusal
// BEHAVIOUR
//  - Reset (async): mem2proc_tag=0, mem2proc_data=0, all slots free, allocation state cleared.
//    Storage contents are NOT reset.
//    Reset mid-operation discards all pending loads; their tags never return.
//  - Addressing: addr[2:0] ignored; address bits above the index are ignored, so addresses wrap modulo MEM_WORDS.
//  - Response:
//    - mem2proc_response = lowest free tag when command is LOAD/STORE and a slot is free; else 0.
//    - Purely combinational from command and slot state.
//  - LOAD accept: at the clock edge, the slot for that tag becomes busy.
//    - Slot captures mem[index] as of that edge, before any store accepted at the same edge.
//    - Slot countdown is loaded with LATENCY-1.
//  - STORE accept:
//    - mem[index] <= proc2mem_data at the edge.
//    - Response is the lowest free tag; no slot is consumed and the tag never appears on mem2proc_tag.
//    - A STORE is refused (response 0) when all slots are busy, so the requester retries uniformly.
//  - Countdown: each busy slot decrements per cycle, saturating at 0; at 0 the slot is ready.
//  - Return: at most one per cycle.
//    - The lowest-numbered ready slot drives mem2proc_tag/mem2proc_data for exactly one cycle.
//    - That slot frees at the same edge.
//    - Other ready slots wait.
//    - mem2proc_tag=0 when nothing is ready; mem2proc_data then holds its last value.
//  - A load accepted at edge N returns at the earliest at edge N+LATENCY, i.e. visible in the cycle after.
//  - Free/retire same edge: a tag freed by a return at edge E is offered by response only in the cycle after E.
//    Response uses registered slot state, with no combinational path from return logic.
//  - Full: all NUM_TAGS slots busy -> response 0 for any command; no state change.
// CONFIGURATION
//  MEM_REFUSE_EN defined:
//    - Adds the mem_busy port.
//    - mem_busy=1 forces response 0 and blocks acceptance; pending returns are unaffected.
//  MEM_REFUSE_EN undefined: no mem_busy port; acceptance depends only on slot availability.
// TESTING
//  1. Reset, store 0xDEAD_BEEF to addr 0x40, then load 0x40 -> response 1 at load.
//     mem2proc_tag=1 with data 0xDEAD_BEEF exactly LATENCY cycles later, for one cycle.
//  2. 15 back-to-back loads -> responses 1..15; 16th load and a store get response 0.
//     After tag 1 returns, the next load gets tag 1.
//  3. Loads accepted on the same edge as stores to the same address -> old data returned.
//     Load one cycle later -> new data.
//  4. Address 0x40 + MEM_WORDS*8 -> aliases word 8; reads back the value stored at 0x40.
//  5. Assert reset with 3 loads pending -> tag 0 immediately, no tags return afterwards.
//     Next load gets tag 1.
//  6. MEM_REFUSE_EN: mem_busy=1 with a load -> response 0, no slot used.
//     An earlier pending load still returns on schedule.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-side responder for the tagged proc/mem bus: 64-bit word store, NUM_TAGS load slots, fixed-latency returns.
// Optional MEM_REFUSE_EN adds a mem_busy input that forces refusal of new commands.

module mem_responder_slot #(
    parameter int LATENCY = 10,
    parameter int CNT_W   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        alloc,
    input  logic        retire,
    input  logic [63:0] load_data,
    output logic        busy,
    output logic        ready,
    output logic [63:0] data
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
            cnt  <= '0;
            data <= '0;
        end else if (alloc) begin
            busy <= 1'b1;
            cnt  <= CNT_W'(LATENCY - 1);
            data <= load_data;
        end else begin
            if (retire)
                busy <= 1'b0;
            if (busy && cnt != '0)
                cnt <= cnt - 1'b1;
        end
    end

    assign ready = busy && (cnt == '0);
endmodule

module mem_responder #(
    parameter int LATENCY   = 10,
    parameter int NUM_TAGS  = 15,
    parameter int MEM_WORDS = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  proc2mem_command,
    input  logic [63:0] proc2mem_addr,
    input  logic [63:0] proc2mem_data,
`ifdef MEM_REFUSE_EN
    input  logic        mem_busy,
`endif
    output logic [3:0]  mem2proc_response,
    output logic [63:0] mem2proc_data,
    output logic [3:0]  mem2proc_tag
);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_cmd_e;

    typedef struct packed {
        logic             load;
        logic             store;
        logic [IDX_W-1:0] idx;
        logic [63:0]      data;
    } mem_req_t;

    logic [63:0] mem [MEM_WORDS];

    mem_req_t                     req;
    logic                         refuse;
    logic                         any_free, any_ready, accept;
    logic [3:0]                   free_tag, ret_tag;
    logic [63:0]                  ret_data;
    logic [NUM_TAGS-1:0]          slot_busy, slot_ready, slot_alloc, slot_retire;
    logic [NUM_TAGS-1:0][63:0]    slot_data;
    logic                         unused_addr_bits;

    assign req.load  = (proc2mem_command == BUS_LOAD);
    assign req.store = (proc2mem_command == BUS_STORE);
    assign req.idx   = proc2mem_addr[3 +: IDX_W];
    assign req.data  = proc2mem_data;

    assign unused_addr_bits = ^{proc2mem_addr[63:3+IDX_W], proc2mem_addr[2:0]};

`ifdef MEM_REFUSE_EN
    assign refuse = mem_busy;
`else
    assign refuse = 1'b0;
`endif

    // Lowest free and lowest ready slot; response sees only registered slot state.
    always_comb begin
        any_free  = 1'b0;
        free_tag  = '0;
        any_ready = 1'b0;
        ret_tag   = '0;
        ret_data  = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!slot_busy[i]) begin
                any_free = 1'b1;
                free_tag = 4'(i + 1);
            end
            if (slot_ready[i]) begin
                any_ready = 1'b1;
                ret_tag   = 4'(i + 1);
                ret_data  = slot_data[i];
            end
        end
    end

    assign accept            = (req.load || req.store) && any_free && !refuse;
    assign mem2proc_response = accept ? free_tag : 4'd0;

    genvar g;
    generate
        for (g = 0; g < NUM_TAGS; g++) begin : g_slot
            assign slot_alloc[g]  = accept && req.load && (free_tag == 4'(g + 1));
            assign slot_retire[g] = any_ready && (ret_tag == 4'(g + 1));

            mem_responder_slot #(
                .LATENCY (LATENCY),
                .CNT_W   (CNT_W)
            ) u_slot (
                .clock     (clock),
                .reset     (reset),
                .alloc     (slot_alloc[g]),
                .retire    (slot_retire[g]),
                .load_data (mem[req.idx]),
                .busy      (slot_busy[g]),
                .ready     (slot_ready[g]),
                .data      (slot_data[g])
            );
        end
    endgenerate

    // Storage is deliberately not reset; loads sample the pre-edge contents.
    always_ff @(posedge clock) begin
        if (accept && req.store)
            mem[req.idx] <= req.data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem2proc_tag  <= '0;
            mem2proc_data <= '0;
        end else if (any_ready) begin
            mem2proc_tag  <= ret_tag;
            mem2proc_data <= ret_data;
        end else begin
            mem2proc_tag  <= '0;
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a due-time/queue reference model.
module tb_mem_responder;
    localparam int LAT = 10;
    localparam int NT  = 15;
    localparam int MW  = 1024;
    localparam int IW  = 10;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  cmd = '0;
    logic [63:0] addr = '0, wdata = '0;
    logic        busy_in = 1'b0;
    logic [3:0]  resp, tag;
    logic [63:0] rdata;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: per-tag due edge and captured data, word map
    bit          mbusy [1:NT];
    longint      mdue  [1:NT];
    logic [63:0] mdat  [1:NT];
    logic [63:0] mm    [int];
    logic [63:0] exp_data = '0;
    longint      edge_n = 0;
    logic [IW-1:0] pool [16];

    always #5 clock = ~clock;

    mem_responder #(.LATENCY(LAT), .NUM_TAGS(NT), .MEM_WORDS(MW)) dut (
        .clock             (clock),
        .reset             (reset),
        .proc2mem_command  (cmd),
        .proc2mem_addr     (addr),
        .proc2mem_data     (wdata),
`ifdef MEM_REFUSE_EN
        .mem_busy          (busy_in),
`endif
        .mem2proc_response (resp),
        .mem2proc_data     (rdata),
        .mem2proc_tag      (tag)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, got, exp, edge_n);
        end
    endtask

    function automatic logic [63:0] mk_addr(input logic [IW-1:0] i);
        logic [63:0] a;
        a = {$urandom, $urandom};
        a[3 +: IW] = i;
        return a;
    endfunction

    task automatic step(input logic [1:0] c, input logic [63:0] a, input logic [63:0] d, input logic b);
        int exp_resp, rt, idx;
        @(negedge clock);
        cmd = c; addr = a; wdata = d; busy_in = b;
        #1;
        exp_resp = 0;
        if ((c == 2'd1 || c == 2'd2) && !b)
            for (int t = 1; t <= NT; t++)
                if (!mbusy[t] && exp_resp == 0) exp_resp = t;
        chk("resp", {60'd0, resp}, 64'(exp_resp));
        @(posedge clock);
        edge_n++;
        rt = 0;
        for (int t = 1; t <= NT; t++)
            if (mbusy[t] && mdue[t] <= edge_n && rt == 0) rt = t;
        if (rt != 0) begin
            exp_data  = mdat[rt];
            mbusy[rt] = 1'b0;
        end
        if (exp_resp != 0) begin
            idx = int'(a[3 +: IW]);
            if (c == 2'd1) begin
                mbusy[exp_resp] = 1'b1;
                mdue[exp_resp]  = edge_n + LAT;
                mdat[exp_resp]  = mm[idx];
            end else begin
                mm[idx] = d;
            end
        end
        #1;
        chk("tag", {60'd0, tag}, 64'(rt));
        chk("data", rdata, exp_data);
    endtask

    task automatic idle(input int n);
        repeat (n) step(2'd0, 64'd0, 64'd0, 1'b0);
    endtask

    task automatic reset_dut();
        @(negedge clock);
        cmd = '0; busy_in = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_tag", {60'd0, tag}, 64'd0);
        chk("rst_data", rdata, 64'd0);
        for (int t = 1; t <= NT; t++) mbusy[t] = 1'b0;
        exp_data = '0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        logic [63:0] v;
        for (int t = 1; t <= NT; t++) begin mbusy[t] = 1'b0; mdue[t] = 0; mdat[t] = '0; end
        reset_dut();
        idle(2);

        // store/load round trip at 0x40
        step(2'd2, 64'h40, 64'hDEAD_BEEF, 1'b0);
        step(2'd1, 64'h40, 64'd0, 1'b0);
        idle(LAT + 2);

        pool[0] = IW'(8);
        for (int i = 1; i < 16; i++) pool[i] = IW'($urandom);
        for (int i = 0; i < 16; i++) step(2'd2, mk_addr(pool[i]), {$urandom, $urandom}, 1'b0);

        // fill all tags, then a refused load and store
        for (int i = 0; i < 16; i++) step(2'd1, mk_addr(pool[$urandom % 16]), 64'd0, 1'b0);
        step(2'd2, mk_addr(pool[1]), 64'h1234, 1'b0);
        idle(LAT - 6);
        step(2'd1, mk_addr(pool[2]), 64'd0, 1'b0);
        idle(LAT + 18);

        // store then immediate load sees new data
        v = {$urandom, $urandom};
        step(2'd2, 64'h40, v, 1'b0);
        step(2'd1, 64'h40, 64'd0, 1'b0);
        // aliasing beyond MEM_WORDS
        step(2'd2, 64'h40 + 64'(MW * 8), 64'hA11A_5000_0000_0001, 1'b0);
        step(2'd1, 64'h40, 64'd0, 1'b0);
        idle(LAT + 2);

        // reset with loads pending
        for (int i = 0; i < 3; i++) step(2'd1, mk_addr(pool[i]), 64'd0, 1'b0);
        reset_dut();
        idle(LAT + 5);
        step(2'd1, mk_addr(pool[3]), 64'd0, 1'b0);
        idle(LAT + 2);

`ifdef MEM_REFUSE_EN
        step(2'd1, mk_addr(pool[4]), 64'd0, 1'b0);
        step(2'd1, mk_addr(pool[5]), 64'd0, 1'b1);
        step(2'd2, mk_addr(pool[5]), 64'hBAD, 1'b1);
        idle(LAT + 2);
`endif

        for (int i = 0; i < 3000; i++) begin
            logic [1:0] c;
            logic       b;
            if (i < 1500) c = ($urandom % 8 < 5) ? 2'd1 : 2'($urandom % 4);
            else          c = 2'($urandom % 4);
            b = 1'b0;
`ifdef MEM_REFUSE_EN
            b = ($urandom % 5 == 0);
`endif
            step(c, mk_addr(pool[$urandom % 16]), {$urandom, $urandom}, b);
        end
        idle(LAT + 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
